// File: rtl/hazard_sched.sv
`default_nettype none
// =============================================================================
// Module : hazard_sched
// Brief  : Stall/forward-select generation and mult/div busy sequencing for
//          the 5-stage pipeline.
// Rev    : 1.0  initial release
// =============================================================================
module hazard_sched #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs_id,
   input  logic [4:0]       rt_id,
   input  logic [1:0]       tuse_rs,
   input  logic [1:0]       tuse_rt,
   input  logic             md_use_id,
   input  logic [4:0]       rs_ex,
   input  logic [4:0]       rt_ex,
   input  logic [4:0]       wa_ex,
   input  logic [1:0]       tnew_ex,
   input  logic             jal_ex,
   input  logic [1:0]       md_kind_ex,
   input  logic [4:0]       rt_mem,
   input  logic [4:0]       wa_mem,
   input  logic [1:0]       tnew_mem,
   input  logic             jal_mem,
   input  logic [4:0]       wa_wb,
   output logic             stall,
   output logic [2:0]       cmpa_for,
   output logic [2:0]       cmpb_for,
   output logic [2:0]       alua_for,
   output logic [2:0]       alub_for,
   output logic [2:0]       dmwd_for,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int c_max_lat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int c_md_w    = ($clog2(c_max_lat + 1) > 4) ? $clog2(c_max_lat + 1) : 4;

   localparam logic [c_md_w-1:0] c_mult_lat = c_md_w'(MULT_LAT);
   localparam logic [c_md_w-1:0] c_div_lat  = c_md_w'(DIV_LAT);
   localparam logic [c_md_w-1:0] c_md_one   = c_md_w'(1);
   localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);

   localparam logic [2:0] c_sel_none    = 3'd0;
   localparam logic [2:0] c_sel_pc8_ex  = 3'd1;
   localparam logic [2:0] c_sel_alu_mem = 3'd2;
   localparam logic [2:0] c_sel_pc8_mem = 3'd3;
   localparam logic [2:0] c_sel_wd_wb   = 3'd4;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } md_state_t;

   md_state_t         r_state;
   logic [c_md_w-1:0] r_cnt;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_rs_ex, w_rs_mem, w_rs_wb;
   logic w_rt_ex, w_rt_mem, w_rt_wb;
   logic w_ars_mem, w_ars_wb, w_art_mem, w_art_wb, w_drt_wb;
   logic w_data_stall, w_md_busy, w_stall;

   function automatic logic match(input logic [4:0] r, input logic [4:0] wa);
      return (r != 5'd0) && (r == wa);
   endfunction

   // The nearest matching stage owns the value; if it cannot supply it yet,
   // no older stage may be used instead.
   function automatic logic [2:0] id_sel(input logic m_ex, input logic m_mem,
                                         input logic m_wb, input logic j_ex,
                                         input logic j_mem, input logic [1:0] t_mem);
      if (m_ex)       return j_ex ? c_sel_pc8_ex : c_sel_none;
      else if (m_mem) return j_mem ? c_sel_pc8_mem :
                             ((t_mem == 2'd0) ? c_sel_alu_mem : c_sel_none);
      else if (m_wb)  return c_sel_wd_wb;
      else            return c_sel_none;
   endfunction

   function automatic logic [2:0] ex_sel(input logic m_mem, input logic m_wb,
                                         input logic j_mem, input logic [1:0] t_mem);
      if (m_mem)     return j_mem ? c_sel_pc8_mem :
                            ((t_mem == 2'd0) ? c_sel_alu_mem : c_sel_none);
      else if (m_wb) return c_sel_wd_wb;
      else           return c_sel_none;
   endfunction

   assign w_rs_ex   = match(rs_id, wa_ex);
   assign w_rs_mem  = match(rs_id, wa_mem);
   assign w_rs_wb   = match(rs_id, wa_wb);
   assign w_rt_ex   = match(rt_id, wa_ex);
   assign w_rt_mem  = match(rt_id, wa_mem);
   assign w_rt_wb   = match(rt_id, wa_wb);
   assign w_ars_mem = match(rs_ex, wa_mem);
   assign w_ars_wb  = match(rs_ex, wa_wb);
   assign w_art_mem = match(rt_ex, wa_mem);
   assign w_art_wb  = match(rt_ex, wa_wb);
   assign w_drt_wb  = match(rt_mem, wa_wb);

   assign cmpa_for = id_sel(w_rs_ex, w_rs_mem, w_rs_wb, jal_ex, jal_mem, tnew_mem);
   assign cmpb_for = id_sel(w_rt_ex, w_rt_mem, w_rt_wb, jal_ex, jal_mem, tnew_mem);
   assign alua_for = ex_sel(w_ars_mem, w_ars_wb, jal_mem, tnew_mem);
   assign alub_for = ex_sel(w_art_mem, w_art_wb, jal_mem, tnew_mem);
   assign dmwd_for = w_drt_wb ? c_sel_wd_wb : c_sel_none;

   assign w_data_stall =
      ((tuse_rs != 2'd3) && ((w_rs_ex && (tuse_rs < tnew_ex)) || (w_rs_mem && (tuse_rs < tnew_mem)))) ||
      ((tuse_rt != 2'd3) && ((w_rt_ex && (tuse_rt < tnew_ex)) || (w_rt_mem && (tuse_rt < tnew_mem))));

   assign w_md_busy = (md_kind_ex != 2'd0) || (r_state == S_BUSY);
   assign w_stall   = w_data_stall || (md_use_id && w_md_busy);

   assign stall     = w_stall;
   assign md_busy   = w_md_busy;
   assign stall_cnt = r_stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + c_cnt_one;

         // A new mult/div always restarts the countdown, even mid-busy.
         if (md_kind_ex == 2'd1) begin
            r_state <= S_BUSY;
            r_cnt   <= c_mult_lat;
         end else if (md_kind_ex == 2'd2) begin
            r_state <= S_BUSY;
            r_cnt   <= c_div_lat;
         end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - c_md_one;
            if (r_cnt == c_md_one)
               r_state <= S_IDLE;
         end
      end
   end

endmodule
`default_nettype wire
